// File: rtl/epsm_pkg.sv
// ---------------------------------------------------------------------------
// epsm_pkg
// Shared constants and types for the EPSM write-capture front end.
//   EPSM_ADDR_HI : cpu_addr[13:2] pattern selecting $401C-$401F
//   ENTRY_W      : width of one queued {port, reg, data} entry
//   REG_*        : EPSM register indices of interest to the timer block
//   ENTRY_*      : bit offsets of the entry fields inside a flat vector
// ---------------------------------------------------------------------------
package epsm_pkg;

  localparam logic [11:0] EPSM_ADDR_HI = 12'h007;

  localparam int ENTRY_W        = 17;
  localparam int ENTRY_PORT_BIT = 16;
  localparam int ENTRY_REG_LSB  = 8;
  localparam int ENTRY_DATA_LSB = 0;

  localparam logic [7:0] REG_24 = 8'h24;
  localparam logic [7:0] REG_25 = 8'h25;
  localparam logic [7:0] REG_26 = 8'h26;
  localparam logic [7:0] REG_27 = 8'h27;
  localparam logic [7:0] REG_29 = 8'h29;

  // Field order matches the ENTRY_* offsets above.
  typedef struct packed {
    logic       port;
    logic [7:0] regi;
    logic [7:0] data;
  } entry_t;

  function automatic entry_t make_entry(input logic port, input logic [7:0] regi,
                                        input logic [7:0] data);
    entry_t e;
    e.port = port;
    e.regi = regi;
    e.data = data;
    return e;
  endfunction

endpackage

// File: rtl/epsm_fifo.sv
// ---------------------------------------------------------------------------
// epsm_fifo
// Synchronous FIFO of epsm_pkg::entry_t, DEPTH entries (power of two, >=2).
// Pointers carry one extra wrap bit so full and empty are told apart.
// The head is held in a register: it updates the clock after a push into an
// empty FIFO or after a pop, and keeps its last value while empty.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   push       : write request; push_data is the entry
//   push_ok    : push accepted this clk (not full, or a pop happens too)
//   pop        : read request; ignored while empty
//   head       : registered head entry
//   empty      : no entries queued
// ---------------------------------------------------------------------------
module epsm_fifo
  import epsm_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   push,
  input  entry_t push_data,
  output logic   push_ok,
  input  logic   pop,
  output entry_t head,
  output logic   empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  entry_t      head_q, head_d;
  entry_t      mem_q [DEPTH];
  logic        full;
  logic        pop_ok;

  always_comb begin
    empty   = (wr_ptr_q == rd_ptr_q);
    full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    pop_ok  = pop && !empty;
    // A pop in the same clk frees the slot, so a full FIFO still accepts.
    push_ok = push && (!full || pop_ok);

    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_ONE;

    head_d = head_q;
    if (wr_ptr_d != rd_ptr_d) begin
      // The entry being written becomes the head when it lands on rd_ptr_d.
      if (push_ok && (wr_ptr_q == rd_ptr_d)) head_d = push_data;
      else                                   head_d = mem_q[rd_ptr_d[AW-1:0]];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      head_q   <= '0;
    end else begin
      // NOTE: state registers use non-blocking assignments so every flop
      // samples the values from before this edge.
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      head_q   <= head_d;
    end
  end

  // NOTE: storage is deliberately not reset; pointers define which slots are
  // valid, and leaving the array reset-free lets it map onto plain RAM.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= push_data;
  end

  assign head = head_q;

endmodule

// File: rtl/epsm_wr_capture.sv
// ---------------------------------------------------------------------------
// epsm_wr_capture
// Snoops CPU writes to $401C-$401F in the clk domain. Address writes
// ($401C port 0, $401E port 1) latch a register index per port; data writes
// ($401D/$401F) queue {port, reg, data} into a FIFO drained via valid/ready.
// m2 is synchronised; the bus is sampled once m2 has been high for CAP_DLY
// clks, and the write commits on the synchronised m2 falling edge.
// Optional feature: define EPSM_OVF_CNT_EN to build the saturating drop
// counter on ovf_cnt; otherwise ovf_cnt is tied to 8'h00.
// Ports:
//   clk, rst           : 50 MHz clock, synchronous active-high reset
//   m2, cpu_ce, cpu_rw : CPU M2 (async), /ROMSEL (active low), R/W (1 = read)
//   cpu_addr, cpu_dat  : CPU A14..A0 and data bus
//   out_valid/out_ready: FIFO head handshake
//   out_port/reg/data  : head entry fields
//   ovf, ovf_clr       : sticky drop flag and its clear
//   ovf_cnt            : saturating drop count
// ---------------------------------------------------------------------------
module epsm_wr_capture
  import epsm_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int CAP_DLY    = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        m2,
  input  logic        cpu_ce,
  input  logic        cpu_rw,
  input  logic [14:0] cpu_addr,
  input  logic [7:0]  cpu_dat,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_port,
  output logic [7:0]  out_reg,
  output logic [7:0]  out_data,
  output logic        ovf,
  input  logic        ovf_clr,
  output logic [7:0]  ovf_cnt
);

  localparam logic [7:0] CAP_CNT = 8'(CAP_DLY);

  logic       m2_meta_q, m2_s_q, m2_prev_q;
  logic [1:0] sync_vld_q, sync_vld_d;
  logic       armed_q, armed_d;
  logic [7:0] hi_cnt_q, hi_cnt_d;
  logic [1:0] samp_addr_q, samp_addr_d;
  logic [7:0] samp_dat_q, samp_dat_d;
  logic       samp_hit_q, samp_hit_d;
  logic [7:0] areg_q [2];
  logic [7:0] areg_d [2];
  logic       ovf_q, ovf_d;

  logic   hit;
  logic   m2_fall;
  logic   push;
  logic   push_ok;
  logic   drop;
  logic   fifo_empty;
  entry_t push_entry;
  entry_t head;

  always_comb begin
    hit     = armed_q && !cpu_rw && cpu_ce && cpu_addr[14] && (cpu_addr[13:2] == EPSM_ADDR_HI);
    m2_fall = m2_prev_q && !m2_s_q;

    // sync_vld marks when m2_s reflects the real pin after reset; arming on
    // the reset-zeroed chain would let a high phase in progress at reset
    // look like a fresh cycle.
    sync_vld_d = {sync_vld_q[0], 1'b1};
    armed_d    = armed_q || (sync_vld_q[1] && !m2_s_q);

    hi_cnt_d = 8'h00;
    if (m2_s_q) hi_cnt_d = (hi_cnt_q == 8'hFF) ? hi_cnt_q : hi_cnt_q + 8'h01;

    samp_addr_d = samp_addr_q;
    samp_dat_d  = samp_dat_q;
    samp_hit_d  = samp_hit_q;
    if (m2_s_q && (hi_cnt_q == CAP_CNT)) begin
      samp_addr_d = cpu_addr[1:0];
      samp_dat_d  = cpu_dat;
      samp_hit_d  = hit;
    end

    areg_d     = areg_q;
    push       = 1'b0;
    push_entry = make_entry(samp_addr_q[1], areg_q[samp_addr_q[1]], samp_dat_q);
    if (m2_fall) begin
      // Consume the sample so a following short phase cannot recommit it.
      samp_hit_d = 1'b0;
      if (samp_hit_q) begin
        if (!samp_addr_q[0]) areg_d[samp_addr_q[1]] = samp_dat_q;
        else                 push = 1'b1;
      end
    end

    drop  = push && !push_ok;
    ovf_d = ovf_q;
    if (ovf_clr) ovf_d = 1'b0;
    if (drop)    ovf_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      m2_meta_q   <= 1'b0;
      m2_s_q      <= 1'b0;
      m2_prev_q   <= 1'b0;
      sync_vld_q  <= 2'b00;
      armed_q     <= 1'b0;
      hi_cnt_q    <= 8'h00;
      samp_addr_q <= 2'b00;
      samp_dat_q  <= 8'h00;
      samp_hit_q  <= 1'b0;
      areg_q[0]   <= 8'h00;
      areg_q[1]   <= 8'h00;
      ovf_q       <= 1'b0;
    end else begin
      m2_meta_q   <= m2;
      m2_s_q      <= m2_meta_q;
      m2_prev_q   <= m2_s_q;
      sync_vld_q  <= sync_vld_d;
      armed_q     <= armed_d;
      hi_cnt_q    <= hi_cnt_d;
      samp_addr_q <= samp_addr_d;
      samp_dat_q  <= samp_dat_d;
      samp_hit_q  <= samp_hit_d;
      areg_q[0]   <= areg_d[0];
      areg_q[1]   <= areg_d[1];
      ovf_q       <= ovf_d;
    end
  end

`ifdef EPSM_OVF_CNT_EN
  logic [7:0] ovf_cnt_q, ovf_cnt_d;

  always_comb begin
    ovf_cnt_d = ovf_cnt_q;
    if (ovf_clr) ovf_cnt_d = 8'h00;
    if (drop && (ovf_cnt_d != 8'hFF)) ovf_cnt_d = ovf_cnt_d + 8'h01;
  end

  always_ff @(posedge clk) begin
    if (rst) ovf_cnt_q <= 8'h00;
    else     ovf_cnt_q <= ovf_cnt_d;
  end

  assign ovf_cnt = ovf_cnt_q;
`else
  assign ovf_cnt = 8'h00;
`endif

  epsm_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_entry),
    .push_ok   (push_ok),
    .pop       (out_ready),
    .head      (head),
    .empty     (fifo_empty)
  );

  assign out_valid = !fifo_empty;
  assign out_port  = head.port;
  assign out_reg   = head.regi;
  assign out_data  = head.data;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_epsm_wr_capture.sv
// ---------------------------------------------------------------------------
// tb_epsm_wr_capture
// Directed bench for epsm_wr_capture (FIFO_DEPTH=4, CAP_DLY=6). Inputs are
// driven and outputs sampled on the falling clk edge. Expected entries are
// hand-computed constants packed as {valid, port, reg, data}.
// ---------------------------------------------------------------------------
module tb_epsm_wr_capture;

  logic        clk = 1'b0;
  logic        rst;
  logic        m2;
  logic        cpu_ce;
  logic        cpu_rw;
  logic [14:0] cpu_addr;
  logic [7:0]  cpu_dat;
  logic        out_valid;
  logic        out_ready;
  logic        out_port;
  logic [7:0]  out_reg;
  logic [7:0]  out_data;
  logic        ovf;
  logic        ovf_clr;
  logic [7:0]  ovf_cnt;

  int checks = 0;
  int errors = 0;

  always #10 clk = ~clk;

  epsm_wr_capture #(
    .FIFO_DEPTH (4),
    .CAP_DLY    (6)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .m2        (m2),
    .cpu_ce    (cpu_ce),
    .cpu_rw    (cpu_rw),
    .cpu_addr  (cpu_addr),
    .cpu_dat   (cpu_dat),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_port  (out_port),
    .out_reg   (out_reg),
    .out_data  (out_data),
    .ovf       (ovf),
    .ovf_clr   (ovf_clr),
    .ovf_cnt   (ovf_cnt)
  );

  // One CPU bus cycle: m2 high for 'hi' clks, then low for 6 clks.
  task automatic bus_cycle(input logic [14:0] a, input logic [7:0] d, input logic rw,
                           input logic ce, input int hi);
    cpu_addr = a;
    cpu_dat  = d;
    cpu_rw   = rw;
    cpu_ce   = ce;
    m2       = 1'b1;
    repeat (hi) @(negedge clk);
    m2 = 1'b0;
    repeat (6) @(negedge clk);
    cpu_rw = 1'b1;
    cpu_ce = 1'b0;
  endtask

  // Observe the head as {valid, port, reg, data}, then pop it for one clk.
  task automatic pop_entry(output logic [17:0] obs);
    obs       = {out_valid, out_port, out_reg, out_data};
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic pulse_ovf_clr();
    ovf_clr = 1'b1;
    @(negedge clk);
    ovf_clr = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; m2 = 1'b0; cpu_ce = 1'b0; cpu_rw = 1'b1;
    cpu_addr = '0; cpu_dat = '0; out_ready = 1'b0; ovf_clr = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({out_valid, out_port, out_reg, out_data, ovf, ovf_cnt} !== 27'h0) begin
      errors++;
      $display("FAIL reset_state: got %h expected %h",
               {out_valid, out_port, out_reg, out_data, ovf, ovf_cnt}, 27'h0);
    end
  endtask

  task automatic test_single_write();
    logic [17:0] obs;
    bus_cycle(15'h401C, 8'h27, 1'b0, 1'b1, 12);
    // Data write with explicit latency checks around the m2 fall.
    cpu_addr = 15'h401D; cpu_dat = 8'h15; cpu_rw = 1'b0; cpu_ce = 1'b1; m2 = 1'b1;
    repeat (12) @(negedge clk);
    m2 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_valid_early: got %b expected %b", out_valid, 1'b0);
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1) begin
      errors++;
      $display("FAIL single_valid_latency: got %b expected %b", out_valid, 1'b1);
    end
    cpu_rw = 1'b1; cpu_ce = 1'b0;
    repeat (3) @(negedge clk);
    pop_entry(obs);
    checks++;
    if (obs !== {1'b1, 1'b0, 8'h27, 8'h15}) begin
      errors++;
      $display("FAIL single_entry: got %h expected %h", obs, {1'b1, 1'b0, 8'h27, 8'h15});
    end
    checks++;
    if ({out_valid, out_data} !== {1'b0, 8'h15}) begin
      errors++;
      $display("FAIL single_empty_hold: got %h expected %h", {out_valid, out_data}, {1'b0, 8'h15});
    end
  endtask

  task automatic test_two_ports();
    logic [17:0] obs;
    bus_cycle(15'h401E, 8'h24, 1'b0, 1'b1, 12);
    bus_cycle(15'h401F, 8'hA5, 1'b0, 1'b1, 12);
    bus_cycle(15'h401C, 8'h26, 1'b0, 1'b1, 12);
    bus_cycle(15'h401D, 8'h40, 1'b0, 1'b1, 12);
    pop_entry(obs);
    checks++;
    if (obs !== {1'b1, 1'b1, 8'h24, 8'hA5}) begin
      errors++;
      $display("FAIL two_ports_first: got %h expected %h", obs, {1'b1, 1'b1, 8'h24, 8'hA5});
    end
    pop_entry(obs);
    checks++;
    if (obs !== {1'b1, 1'b0, 8'h26, 8'h40}) begin
      errors++;
      $display("FAIL two_ports_second: got %h expected %h", obs, {1'b1, 1'b0, 8'h26, 8'h40});
    end
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL two_ports_drained: got %b expected %b", out_valid, 1'b0);
    end
  endtask

  task automatic test_overflow();
    logic [7:0] exp_cnt;
`ifdef EPSM_OVF_CNT_EN
    exp_cnt = 8'h02;
`else
    exp_cnt = 8'h00;
`endif
    pulse_ovf_clr();
    for (int i = 0; i < 6; i++) bus_cycle(15'h401D, 8'h10 + 8'(i), 1'b0, 1'b1, 12);
    checks++;
    if ({out_valid, ovf, ovf_cnt} !== {1'b1, 1'b1, exp_cnt}) begin
      errors++;
      $display("FAIL overflow_flags: got %h expected %h", {out_valid, ovf, ovf_cnt},
               {1'b1, 1'b1, exp_cnt});
    end
    checks++;
    if ({out_port, out_reg, out_data} !== {1'b0, 8'h26, 8'h10}) begin
      errors++;
      $display("FAIL overflow_head: got %h expected %h", {out_port, out_reg, out_data},
               {1'b0, 8'h26, 8'h10});
    end
    pulse_ovf_clr();
    checks++;
    if ({ovf, ovf_cnt, out_valid} !== {1'b0, 8'h00, 1'b1}) begin
      errors++;
      $display("FAIL overflow_clear: got %h expected %h", {ovf, ovf_cnt, out_valid},
               {1'b0, 8'h00, 1'b1});
    end
  endtask

  // FIFO still holds 10h..13h; pop exactly on the push clk.
  task automatic test_full_push_pop();
    logic [17:0] obs;
    logic [7:0]  exp_data [4];
    exp_data[0] = 8'h11; exp_data[1] = 8'h12; exp_data[2] = 8'h13; exp_data[3] = 8'h77;
    cpu_addr = 15'h401D; cpu_dat = 8'h77; cpu_rw = 1'b0; cpu_ce = 1'b1; m2 = 1'b1;
    repeat (12) @(negedge clk);
    m2 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    cpu_rw = 1'b1; cpu_ce = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({ovf, ovf_cnt} !== 9'h000) begin
      errors++;
      $display("FAIL full_push_ovf: got %h expected %h", {ovf, ovf_cnt}, 9'h000);
    end
    for (int i = 0; i < 4; i++) begin
      pop_entry(obs);
      checks++;
      if (obs !== {1'b1, 1'b0, 8'h26, exp_data[i]}) begin
        errors++;
        $display("FAIL full_push_entry%0d: got %h expected %h", i, obs,
                 {1'b1, 1'b0, 8'h26, exp_data[i]});
      end
    end
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL full_push_drained: got %b expected %b", out_valid, 1'b0);
    end
  endtask

  task automatic test_ignored_cycles();
    logic [17:0] obs;
    bus_cycle(15'h401C, 8'h33, 1'b0, 1'b1, 12);
    bus_cycle(15'h401D, 8'hE0, 1'b1, 1'b1, 12);  // read
    bus_cycle(15'h401B, 8'hE1, 1'b0, 1'b1, 12);  // below window
    bus_cycle(15'h4020, 8'hE2, 1'b0, 1'b1, 12);  // above window
    bus_cycle(15'h401D, 8'hE3, 1'b0, 1'b0, 12);  // $C01D, ROM select active
    bus_cycle(15'h401C, 8'h99, 1'b0, 1'b0, 12);  // $C01C, must not touch areg
    bus_cycle(15'h401D, 8'hE4, 1'b0, 1'b1, 4);   // phase shorter than CAP_DLY
    bus_cycle(15'h401C, 8'h98, 1'b0, 1'b1, 4);   // short address write
    checks++;
    if ({out_valid, ovf} !== 2'b00) begin
      errors++;
      $display("FAIL ignored_no_entry: got %b expected %b", {out_valid, ovf}, 2'b00);
    end
    bus_cycle(15'h401D, 8'h44, 1'b0, 1'b1, 12);
    pop_entry(obs);
    checks++;
    if (obs !== {1'b1, 1'b0, 8'h33, 8'h44}) begin
      errors++;
      $display("FAIL ignored_areg_kept: got %h expected %h", obs, {1'b1, 1'b0, 8'h33, 8'h44});
    end
  endtask

  task automatic test_reset_mid_cycle();
    logic [17:0] obs;
    bus_cycle(15'h401F, 8'h61, 1'b0, 1'b1, 12);
    checks++;
    if (out_valid !== 1'b1) begin
      errors++;
      $display("FAIL midrst_prefill: got %b expected %b", out_valid, 1'b1);
    end
    cpu_addr = 15'h401D; cpu_dat = 8'hAA; cpu_rw = 1'b0; cpu_ce = 1'b1; m2 = 1'b1;
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    m2 = 1'b0;
    repeat (6) @(negedge clk);
    cpu_rw = 1'b1; cpu_ce = 1'b0;
    checks++;
    if ({out_valid, out_port, out_reg, out_data, ovf} !== 19'h0) begin
      errors++;
      $display("FAIL midrst_discard: got %h expected %h",
               {out_valid, out_port, out_reg, out_data, ovf}, 19'h0);
    end
    bus_cycle(15'h401D, 8'h5A, 1'b0, 1'b1, 12);
    pop_entry(obs);
    checks++;
    if (obs !== {1'b1, 1'b0, 8'h00, 8'h5A}) begin
      errors++;
      $display("FAIL midrst_recover: got %h expected %h", obs, {1'b1, 1'b0, 8'h00, 8'h5A});
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_single_write();
    test_two_ports();
    test_overflow();
    test_full_push_pop();
    test_ignored_cycles();
    test_reset_mid_cycle();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
